vending_machine: RTL and testbench
==================================

Name: vending_machine

Overview:
- Coin-operated vending controller for three products: Lemonwater, Sodabottle and Waterbottle.
- Accepts 5 and 10 rupee coins, tracks stock per product, dispenses the selected product and returns change.
- Supports cancel with full refund.
- Top-level leaf block, single clock domain, all outputs registered.

Parameters:
- PRICE_LEMON, 10, price of Lemonwater in rupees (5-bit).
- PRICE_SODA, 20, price of Sodabottle in rupees.
- PRICE_WATER, 15, price of Waterbottle in rupees.
- TIMEOUT_CYCLES, 64, idle cycles in COLLECT before auto-refund (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Fiverupee  in  1  5 Rs coin; each high cycle counts as one coin.
- Tenrupee  in  1  10 Rs coin; each high cycle counts as one coin.
- Lemonwater  in  1  select Lemonwater.
- Sodabottle  in  1  select Sodabottle.
- Waterbottle  in  1  select Waterbottle.
- cancel  in  1  abort purchase, refund credit.
- Lemonwater_added  in  5  stocked Lemonwater count.
- Sodabottle_added  in  5  stocked Sodabottle count.
- Waterbottle_added  in  5  stocked Waterbottle count.
- Lemonwater_available  out  5  remaining Lemonwater stock.
- Sodabottle_available  out  5  remaining Sodabottle stock.
- Waterbottle_available  out  5  remaining Waterbottle stock.
- coincount  out  5  current credit in rupees.
- product  out  2  dispensed product code: 00 none, 01 lemon, 10 soda, 11 water.
- give  out  1  one-cycle dispense strobe.
- change  out  5  change or refund amount, valid with the return/give cycle.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
- Reset clears coincount, product, give, change, selection and all sold counters to 0.

Stock:
- Each product has a 5-bit sold counter.
- X_available = X_added - sold when X_added > sold, else 0 (combinational from registers).
- A sold counter clears to 0 on the cycle after its X_added value changes; X_added is registered for edge compare.

States: IDLE, COLLECT, DISPENSE, REFUND.

IDLE:
- Coins are ignored.
- A select input high with its stock > 0 latches that product and moves to COLLECT.
- If several selects are high, priority is Lemonwater > Sodabottle > Waterbottle.
- A select with stock 0 is ignored and the state stays IDLE.

COLLECT:
- Each cycle: coincount += 5*Fiverupee + 10*Tenrupee. Both high adds 15.
- coincount saturates at 31.
- cancel takes priority over coins that cycle and moves to REFUND.
- When the updated coincount >= price of the latched product, the next state is DISPENSE.
- Select inputs are ignored.

DISPENSE (one cycle):
- give=1, product=code, change=coincount-price.
- Increments that product's sold counter.
- Next cycle: coincount=0, give=0, product=00, change=0, state=IDLE.

REFUND (one cycle):
- give=0, product=00, change=coincount.
- Next cycle: coincount=0, change=0, state=IDLE.

Default outputs: give, product and change are 0 outside DISPENSE/REFUND. coincount holds the credit.

Latency: the dispense strobe appears 1 cycle after the sufficient-credit coin cycle.

Reset mid-operation: credit is discarded with no refund strobe.

Optional Feature:
- Macro VEND_TIMEOUT_EN.
- When defined: in COLLECT, a counter counts consecutive cycles with no coin and no cancel. At TIMEOUT_CYCLES, the state goes to REFUND exactly as for cancel. The counter resets on any coin and on state entry.
- When undefined: no timeout; COLLECT waits indefinitely.

Test Plan:
- Reset released with Waterbottle_added=5 -> Waterbottle_available=5, coincount=0, give=0, product=00, change=0.
- Waterbottle pulse, then Tenrupee for 1 cycle, then Fiverupee for 1 cycle -> coincount 10 then 15. Next cycle: give=1, product=11, change=0. Then Waterbottle_available=4 and coincount=0.
- Sodabottle_added=2, select soda, three Tenrupee cycles -> coincount 10, 20 triggers dispense: give=1, product=10, change=0. Then Sodabottle_available=1.
- Select lemon, Tenrupee and Fiverupee high in the same cycle -> coincount=15. Next cycle: give=1, product=01, change=5.
- Select water, Fiverupee 1 cycle, cancel -> REFUND cycle: change=5, give=0, product=00. Then coincount=0 and stock unchanged.
- Lemonwater_added=0, select lemon, insert coins -> stays IDLE; coincount=0, give never asserted.

Source files
------------

// File: rtl/vending_machine.sv
// rtl/vending_machine.sv - coin-operated vending controller with per-product stock tracking
//
// Three products (lemon=01, soda=10, water=11) bought with 5/10 rupee coins.
// Optional build macro: VEND_TIMEOUT_EN (auto-refund after TIMEOUT_CYCLES idle COLLECT cycles).
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous active-low reset
//   Fiverupee / Tenrupee     coin inputs, one coin per high cycle
//   Lemonwater / Sodabottle / Waterbottle   product selects
//   cancel                   abort purchase, refund credit
//   *_added      [4:0]       stocked count per product
//   *_available  [4:0]       remaining stock per product
//   coincount    [4:0]       current credit
//   product      [1:0]       dispensed product code
//   give                     one-cycle dispense strobe
//   change       [4:0]       change / refund amount
module vending_machine #(
  parameter logic [4:0] PRICE_LEMON    = 5'd10,
  parameter logic [4:0] PRICE_SODA     = 5'd20,
  parameter logic [4:0] PRICE_WATER    = 5'd15,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Fiverupee,
  input  logic       Tenrupee,
  input  logic       Lemonwater,
  input  logic       Sodabottle,
  input  logic       Waterbottle,
  input  logic       cancel,
  input  logic [4:0] Lemonwater_added,
  input  logic [4:0] Sodabottle_added,
  input  logic [4:0] Waterbottle_added,
  output logic [4:0] Lemonwater_available,
  output logic [4:0] Sodabottle_available,
  output logic [4:0] Waterbottle_available,
  output logic [4:0] coincount,
  output logic [1:0] product,
  output logic       give,
  output logic [4:0] change
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_REFUND} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [4:0] r_coincount, w_coin_nxt;
  logic       r_give, w_give_nxt;
  logic [1:0] r_product, w_product_nxt;
  logic [4:0] r_change, w_change_nxt;
  logic [4:0] r_added_l, r_added_s, r_added_w;
  logic [4:0] r_sold_l, r_sold_s, r_sold_w;
  logic [4:0] w_avail_l, w_avail_s, w_avail_w;
  logic [4:0] w_price;
  logic [5:0] w_add, w_sum;
  logic [4:0] w_credit;
  logic       w_coin_in;
  logic       w_timeout;

  assign w_avail_l = (r_added_l > r_sold_l) ? (r_added_l - r_sold_l) : 5'd0;
  assign w_avail_s = (r_added_s > r_sold_s) ? (r_added_s - r_sold_s) : 5'd0;
  assign w_avail_w = (r_added_w > r_sold_w) ? (r_added_w - r_sold_w) : 5'd0;

  assign w_coin_in = Fiverupee | Tenrupee;
  assign w_add     = ({6{Fiverupee}} & 6'd5) + ({6{Tenrupee}} & 6'd10);
  assign w_sum     = {1'b0, r_coincount} + w_add;
  assign w_credit  = (w_sum > 6'd31) ? 5'd31 : w_sum[4:0];

  always_comb begin
    case (r_sel)
      2'd1:    w_price = PRICE_LEMON;
      2'd2:    w_price = PRICE_SODA;
      2'd3:    w_price = PRICE_WATER;
      default: w_price = 5'd31;
    endcase
  end

`ifdef VEND_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_idle_cnt;

  // Counts consecutive coin-free, cancel-free COLLECT cycles; zero outside COLLECT
  // so it starts fresh on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_idle_cnt <= '0;
    else if (r_state != S_COLLECT || w_coin_in)
      r_idle_cnt <= '0;
    else if (!cancel)
      r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_COLLECT) && !w_coin_in && !cancel &&
                     (int'(r_idle_cnt) == TIMEOUT_CYCLES - 1);
`else
  // No timeout in this build; COLLECT waits indefinitely.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state and next-output logic; outputs are registered from these values so
  // they are valid during the DISPENSE / REFUND state itself.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_coin_nxt    = r_coincount;
    w_give_nxt    = 1'b0;
    w_product_nxt = 2'd0;
    w_change_nxt  = 5'd0;
    case (r_state)
      S_IDLE: begin
        if (Lemonwater && w_avail_l != 5'd0) begin
          w_sel_nxt   = 2'd1;
          w_state_nxt = S_COLLECT;
        end else if (Sodabottle && w_avail_s != 5'd0) begin
          w_sel_nxt   = 2'd2;
          w_state_nxt = S_COLLECT;
        end else if (Waterbottle && w_avail_w != 5'd0) begin
          w_sel_nxt   = 2'd3;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel || w_timeout) begin
          w_state_nxt  = S_REFUND;
          w_change_nxt = r_coincount;
        end else begin
          w_coin_nxt = w_credit;
          if (w_credit >= w_price) begin
            w_state_nxt   = S_DISPENSE;
            w_give_nxt    = 1'b1;
            w_product_nxt = r_sel;
            w_change_nxt  = w_credit - w_price;
          end
        end
      end
      S_DISPENSE, S_REFUND: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = 2'd0;
        w_coin_nxt  = 5'd0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sel       <= 2'd0;
      r_coincount <= 5'd0;
      r_give      <= 1'b0;
      r_product   <= 2'd0;
      r_change    <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_coincount <= w_coin_nxt;
      r_give      <= w_give_nxt;
      r_product   <= w_product_nxt;
      r_change    <= w_change_nxt;
    end
  end

  // A restock (any change of the added count) restarts the sold tally; restock
  // wins over a same-cycle sale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_added_l <= 5'd0;
      r_added_s <= 5'd0;
      r_added_w <= 5'd0;
      r_sold_l  <= 5'd0;
      r_sold_s  <= 5'd0;
      r_sold_w  <= 5'd0;
    end else begin
      r_added_l <= Lemonwater_added;
      r_added_s <= Sodabottle_added;
      r_added_w <= Waterbottle_added;
      if (Lemonwater_added != r_added_l)
        r_sold_l <= 5'd0;
      else if (r_state == S_DISPENSE && r_sel == 2'd1)
        r_sold_l <= r_sold_l + 5'd1;
      if (Sodabottle_added != r_added_s)
        r_sold_s <= 5'd0;
      else if (r_state == S_DISPENSE && r_sel == 2'd2)
        r_sold_s <= r_sold_s + 5'd1;
      if (Waterbottle_added != r_added_w)
        r_sold_w <= 5'd0;
      else if (r_state == S_DISPENSE && r_sel == 2'd3)
        r_sold_w <= r_sold_w + 5'd1;
    end
  end

  assign Lemonwater_available  = w_avail_l;
  assign Sodabottle_available  = w_avail_s;
  assign Waterbottle_available = w_avail_w;
  assign coincount             = r_coincount;
  assign product               = r_product;
  assign give                  = r_give;
  assign change                = r_change;

endmodule

// File: tb/tb_vending_machine.sv
// tb/tb_vending_machine.sv - table-driven self-checking bench for vending_machine
module tb_vending_machine;

  logic       clk;
  logic       reset;
  logic       Fiverupee, Tenrupee, Lemonwater, Sodabottle, Waterbottle, cancel;
  logic [4:0] Lemonwater_added, Sodabottle_added, Waterbottle_added;
  logic [4:0] Lemonwater_available, Sodabottle_available, Waterbottle_available;
  logic [4:0] coincount;
  logic [1:0] product;
  logic       give;
  logic [4:0] change;

  int checks;
  int failures;

  vending_machine dut (
    .clk                   (clk),
    .reset                 (reset),
    .Fiverupee             (Fiverupee),
    .Tenrupee              (Tenrupee),
    .Lemonwater            (Lemonwater),
    .Sodabottle            (Sodabottle),
    .Waterbottle           (Waterbottle),
    .cancel                (cancel),
    .Lemonwater_added      (Lemonwater_added),
    .Sodabottle_added      (Sodabottle_added),
    .Waterbottle_added     (Waterbottle_added),
    .Lemonwater_available  (Lemonwater_available),
    .Sodabottle_available  (Sodabottle_available),
    .Waterbottle_available (Waterbottle_available),
    .coincount             (coincount),
    .product               (product),
    .give                  (give),
    .change                (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       f, t, l, s, w, c;
    logic [4:0] la, sa, wa;
    logic [4:0] coin;
    logic       give;
    logic [1:0] prod;
    logic [4:0] chg;
    logic [4:0] lav, sav, wav;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic f, t, l, s, w, c,
                         input logic [4:0] la, sa, wa,
                         input logic [4:0] coin, input logic g, input logic [1:0] prod,
                         input logic [4:0] chg, input logic [4:0] lav, sav, wav);
    vec_t v;
    v.f = f; v.t = t; v.l = l; v.s = s; v.w = w; v.c = c;
    v.la = la; v.sa = sa; v.wa = wa;
    v.coin = coin; v.give = g; v.prod = prod; v.chg = chg;
    v.lav = lav; v.sav = sav; v.wav = wav;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, t, l, s, w, c);
    Fiverupee = f; Tenrupee = t; Lemonwater = l;
    Sodabottle = s; Waterbottle = w; cancel = c;
  endtask

  task automatic step(input logic f, t, l, s, w, c);
    @(negedge clk);
    drive(f, t, l, s, w, c);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] coin, input logic g,
                         input logic [1:0] prod, input logic [4:0] chg);
    chk({tag, ".coincount"}, {3'b0, coincount}, {3'b0, coin});
    chk({tag, ".give"},      {7'b0, give},      {7'b0, g});
    chk({tag, ".product"},   {6'b0, product},   {6'b0, prod});
    chk({tag, ".change"},    {3'b0, change},    {3'b0, chg});
  endtask

  int give_seen;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    Lemonwater_added = 5'd3;
    Sodabottle_added = 5'd0;
    Waterbottle_added = 5'd5;

    //  f t l s w c  la sa wa  coin g p chg  lav sav wav
    add_vec(0,0,0,0,1,0, 3,0,5,  0,0,0,0, 3,0,5);
    add_vec(0,1,0,0,0,0, 3,0,5, 10,0,0,0, 3,0,5);
    add_vec(1,0,0,0,0,0, 3,0,5, 15,1,3,0, 3,0,5);
    add_vec(0,0,0,0,0,0, 3,0,5,  0,0,0,0, 3,0,4);
    add_vec(0,0,0,0,0,0, 3,2,5,  0,0,0,0, 3,2,4);
    add_vec(0,0,0,1,0,0, 3,2,5,  0,0,0,0, 3,2,4);
    add_vec(0,1,0,0,0,0, 3,2,5, 10,0,0,0, 3,2,4);
    add_vec(0,1,0,0,0,0, 3,2,5, 20,1,2,0, 3,2,4);
    add_vec(0,1,0,0,0,0, 3,2,5,  0,0,0,0, 3,1,4);
    add_vec(0,0,1,0,0,0, 3,2,5,  0,0,0,0, 3,1,4);
    add_vec(1,1,0,0,0,0, 3,2,5, 15,1,1,5, 3,1,4);
    add_vec(0,0,0,0,0,0, 3,2,5,  0,0,0,0, 2,1,4);
    add_vec(0,0,0,0,1,0, 3,2,5,  0,0,0,0, 2,1,4);
    add_vec(1,0,0,0,0,0, 3,2,5,  5,0,0,0, 2,1,4);
    add_vec(0,0,0,0,0,1, 3,2,5,  5,0,0,5, 2,1,4);
    add_vec(0,0,0,0,0,0, 3,2,5,  0,0,0,0, 2,1,4);
    add_vec(0,0,0,0,0,0, 0,2,5,  0,0,0,0, 0,1,4);
    add_vec(0,0,1,0,0,0, 0,2,5,  0,0,0,0, 0,1,4);
    add_vec(0,1,0,0,0,0, 0,2,5,  0,0,0,0, 0,1,4);
    add_vec(1,1,1,0,0,0, 0,2,5,  0,0,0,0, 0,1,4);
    add_vec(0,0,0,0,0,0, 1,2,5,  0,0,0,0, 1,1,4);
    add_vec(0,0,1,1,1,0, 1,2,5,  0,0,0,0, 1,1,4);
    add_vec(0,1,0,0,0,0, 1,2,5, 10,1,1,0, 1,1,4);
    add_vec(0,0,0,0,0,0, 1,2,5,  0,0,0,0, 0,1,4);
    add_vec(0,0,0,0,1,0, 1,2,5,  0,0,0,0, 0,1,4);
    add_vec(1,0,0,0,0,0, 1,2,5,  5,0,0,0, 0,1,4);
    add_vec(0,1,0,0,0,1, 1,2,5,  5,0,0,5, 0,1,4);
    add_vec(0,0,0,0,0,0, 1,2,5,  0,0,0,0, 0,1,4);
    add_vec(1,0,0,0,0,0, 1,2,5,  0,0,0,0, 0,1,4);

    // Reset state while asserted and shortly after release.
    #12;
    chk_out("reset", 5'd0, 1'b0, 2'd0, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_out("post_reset", 5'd0, 1'b0, 2'd0, 5'd0);
    chk("post_reset.water_avail", {3'b0, Waterbottle_available}, 8'd5);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].f, vecs[i].t, vecs[i].l, vecs[i].s, vecs[i].w, vecs[i].c);
      Lemonwater_added  = vecs[i].la;
      Sodabottle_added  = vecs[i].sa;
      Waterbottle_added = vecs[i].wa;
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].coin, vecs[i].give, vecs[i].prod, vecs[i].chg);
      chk($sformatf("vec%0d.lemon_avail", i), {3'b0, Lemonwater_available},  {3'b0, vecs[i].lav});
      chk($sformatf("vec%0d.soda_avail", i),  {3'b0, Sodabottle_available},  {3'b0, vecs[i].sav});
      chk($sformatf("vec%0d.water_avail", i), {3'b0, Waterbottle_available}, {3'b0, vecs[i].wav});
    end

    // COLLECT with no coins waits indefinitely.
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    give_seen = 0;
    for (int i = 0; i < 70; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (give || change != 5'd0) give_seen++;
    end
    chk("wait.no_strobe", give_seen[7:0], 8'd0);
    chk("wait.credit_held", {3'b0, coincount}, 8'd5);
    step(0, 1, 0, 0, 0, 0);
    chk_out("wait.dispense", 5'd15, 1'b1, 2'd3, 5'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("wait.water_avail", {3'b0, Waterbottle_available}, 8'd3);

    // Reset mid-purchase discards credit without a refund strobe.
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("midreset.credit", {3'b0, coincount}, 8'd5);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("midreset.async", 5'd0, 1'b0, 2'd0, 5'd0);
    @(posedge clk);
    #1;
    chk_out("midreset.held", 5'd0, 1'b0, 2'd0, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midreset.water_avail", {3'b0, Waterbottle_available}, 8'd5);
    chk("midreset.soda_avail",  {3'b0, Sodabottle_available},  8'd2);
    chk("midreset.lemon_avail", {3'b0, Lemonwater_available},  8'd1);
    step(0, 1, 0, 0, 0, 0);
    chk_out("midreset.idle", 5'd0, 1'b0, 2'd0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
